// File: rtl/d_flipflop.sv
// d_flipflop: WIDTH-bit D register with a synchronous, active-high reset.
// Ports: clk (rising edge), rst (sync reset), d (data in), q (registered out).
module d_flipflop #(
   parameter int unsigned          WIDTH       = 1,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   // No enable: the next state is always the data input.
   always_comb begin
      q_d = d;
   end

   // rst is only looked at on the clock edge and wins over d.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= RESET_VALUE;
      end else begin
         q_q <= q_d;
      end
   end

   // Output comes straight from the register.
   assign q = q_q;

endmodule

// File: tb/tb_d_flipflop.sv
// tb_d_flipflop: directed vectors for a 1-bit and an 8-bit (reset A5) flop.
// Expected values are queued at stimulus time and checked after each edge.
`timescale 1ns/1ps
module tb_d_flipflop;

   typedef struct {
      logic       q1;
      logic [7:0] q8;
      string      name;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       d1;
   logic [7:0] d8;
   logic       q1;
   logic [7:0] q8;

   exp_t sb[$];
   int   checks;
   int   errors;

   d_flipflop u_dut1 (
      .clk (clk),
      .rst (rst),
      .d   (d1),
      .q   (q1)
   );

   d_flipflop #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) u_dut8 (
      .clk (clk),
      .rst (rst),
      .d   (d8),
      .q   (q8)
   );

   initial clk = 1'b0;
   always #2 clk = ~clk;

   // Monitor: after every rising edge, compare against the oldest entry.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (q1 !== e.q1) begin
               errors++;
               $display("FAIL %s q1: got %b want %b", e.name, q1, e.q1);
            end
            checks++;
            if (q8 !== e.q8) begin
               errors++;
               $display("FAIL %s q8: got %h want %h", e.name, q8, e.q8);
            end
         end
      end
   end

   // Drive one cycle mid-low-phase and queue what q must show after the edge.
   task automatic cyc(input logic r, input logic a, input logic [7:0] b,
                      input logic e1, input logic [7:0] e8,
                      input string nm);
      exp_t e;
      @(negedge clk);
      #1;
      rst = r;
      d1  = a;
      d8  = b;
      e.q1 = e1;
      e.q8 = e8;
      e.name = nm;
      sb.push_back(e);
   endtask

   // rst pulses high within the low phase but is 0 at the edge.
   task automatic rst_glitch(input logic a, input logic [7:0] b,
                             input logic e1, input logic [7:0] e8,
                             input string nm);
      exp_t e;
      @(negedge clk);
      rst = 1'b1;
      d1  = a;
      d8  = b;
      #1;
      rst = 1'b0;
      e.q1 = e1;
      e.q8 = e8;
      e.name = nm;
      sb.push_back(e);
   endtask

   // d pulses 0->1->0 within the low phase.
   task automatic d_glitch(input string nm);
      exp_t e;
      @(negedge clk);
      rst = 1'b0;
      d1  = 1'b1;
      d8  = 8'hFF;
      #1;
      d1 = 1'b0;
      d8 = 8'h00;
      e.q1 = 1'b0;
      e.q8 = 8'h00;
      e.name = nm;
      sb.push_back(e);
   endtask

   initial begin
      int wait_cyc;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      d1  = 1'b1;
      d8  = 8'hFF;

      cyc(1'b1, 1'b1, 8'hFF, 1'b0, 8'hA5, "reset_edge1");
      cyc(1'b1, 1'b1, 8'hFF, 1'b0, 8'hA5, "reset_edge2");

      cyc(1'b0, 1'b1, 8'h3C, 1'b1, 8'h3C, "track0");
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "track1");
      cyc(1'b0, 1'b1, 8'h81, 1'b1, 8'h81, "track2");
      cyc(1'b0, 1'b1, 8'h7E, 1'b1, 8'h7E, "track3");
      cyc(1'b0, 1'b0, 8'hFF, 1'b0, 8'hFF, "track4");
      cyc(1'b0, 1'b1, 8'h5A, 1'b1, 8'h5A, "track5");

      cyc(1'b1, 1'b1, 8'h5A, 1'b0, 8'hA5, "mid_reset");
      cyc(1'b0, 1'b1, 8'hC3, 1'b1, 8'hC3, "reset_release");

      rst_glitch(1'b0, 8'h12, 1'b0, 8'h12, "rst_between0");
      rst_glitch(1'b1, 8'h34, 1'b1, 8'h34, "rst_between1");

      cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "pre_glitch");
      d_glitch("d_glitch");

      wait_cyc = 0;
      while (sb.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000;
      $display("FAIL timeout: got stuck want finish");
      $fatal(1, "timeout");
   end

endmodule
